// File: rtl/i2c_tmp101_read_sequencer.sv
// TMP101 read sequencer: START, addr+R, ACK, two data bytes (ACK/NACK), STOP; 12-bit result.
// Latency 116 quarter-ticks (44 on address NACK); Go is ignored while Busy, no other backpressure.
module i2c_tmp101_read_sequencer #(
  parameter int         ClockFrequency = 60000000,
  parameter int         BaudRate       = 30000,
  parameter logic [6:0] SlaveAddress   = 7'b1001000
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        Go,
  output logic        SCL,
  inout  wire         SDA,
  output logic        Busy,
  output logic        Done,
  output logic        AckError,
  output logic [11:0] Temperature
);
  localparam int QuarterCount = ClockFrequency / (4 * BaudRate);
  localparam int CntW = (QuarterCount > 1) ? $clog2(QuarterCount) : 1;
  localparam logic [CntW-1:0] TermCount = CntW'(QuarterCount - 1);
  localparam logic [7:0] AddrByte = {SlaveAddress, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_READ_MSB,
    S_M_ACK, S_READ_LSB, S_M_NACK, S_STOP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CntW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [1:0]       quarter_q, quarter_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      shift_q, shift_d;
  logic             ack_err_q, ack_err_d;
  logic [11:0]      temp_q, temp_d;

  logic busy, tick, sample, slot_end, slot_scl, sda_low, sda_in;

  // Open-drain: only ever pull low or release.
  assign SDA    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tick     = busy && (tick_cnt_q == TermCount);
  assign sample   = tick && (quarter_q == 2'd2);
  assign slot_end = tick && (quarter_q == 2'd3);
  assign slot_scl = quarter_q[0] ^ quarter_q[1];

  assign Busy        = busy;
  assign Done        = (state_q == S_DONE);
  assign AckError    = ack_err_q;
  assign Temperature = temp_q;

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      quarter_q  <= 2'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 16'h0000;
      ack_err_q  <= 1'b0;
      temp_q     <= 12'h000;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      quarter_q  <= quarter_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ack_err_q  <= ack_err_d;
      temp_q     <= temp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = '0;
    quarter_d  = quarter_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ack_err_d  = ack_err_q;
    temp_d     = temp_q;

    if (busy) tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    if (tick) quarter_d = quarter_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        quarter_d = 2'd0;
        bit_cnt_d = 3'd0;
        if (Go) begin
          state_d   = S_START;
          ack_err_d = 1'b0;
        end
      end
      S_START: if (slot_end) state_d = S_ADDR;
      S_ADDR: if (slot_end) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        if (sample) ack_err_d = sda_in;
        if (slot_end) state_d = ack_err_q ? S_STOP : S_READ_MSB;
      end
      S_READ_MSB, S_READ_LSB: begin
        if (sample) shift_d = {shift_q[14:0], sda_in};
        if (slot_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = (state_q == S_READ_MSB) ? S_M_ACK : S_M_NACK;
        end
      end
      S_M_ACK:  if (slot_end) state_d = S_READ_LSB;
      S_M_NACK: if (slot_end) state_d = S_STOP;
      S_STOP:   if (slot_end) state_d = S_DONE;
      S_DONE: begin
        // A NACKed address leaves the previous reading in place.
        if (!ack_err_q) temp_d = {shift_q[15:8], shift_q[7:4]};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    SCL     = 1'b1;
    sda_low = 1'b0;
    case (state_q)
      S_START: begin
        SCL     = (quarter_q <= 2'd1);
        sda_low = (quarter_q != 2'd0);
      end
      S_ADDR: begin
        SCL     = slot_scl;
        sda_low = !AddrByte[3'd7 - bit_cnt_q];
      end
      S_ADDR_ACK, S_READ_MSB, S_READ_LSB, S_M_NACK: SCL = slot_scl;
      S_M_ACK: begin
        SCL     = slot_scl;
        sda_low = 1'b1;
      end
      S_STOP: begin
        SCL     = (quarter_q != 2'd0);
        sda_low = (quarter_q <= 2'd1);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_tmp101_read_sequencer.sv
// Directed bench for the TMP101 read sequencer with a simple open-drain slave and bus monitor.
module tb_i2c_tmp101_read_sequencer;
  logic        clk = 1'b0;
  logic        rst, go;
  logic        scl, busy, done, ack_err;
  logic [11:0] temp;
  wire         sda;

  logic        slv_drv = 1'b0;
  logic        slave_en;
  logic [7:0]  slv_msb, slv_lsb;
  logic        mon_clr;
  logic        scl_p, sda_p;
  int          nrise, start_cnt, stop_cnt, done_cnt;
  logic [31:0] bus_bits;

  int n_checks = 0;
  int n_pass   = 0;

  pullup (sda);
  assign sda = slv_drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_tmp101_read_sequencer #(
    .ClockFrequency(400),
    .BaudRate      (25),
    .SlaveAddress  (7'b1001000)
  ) dut (
    .clock      (clk),
    .Reset      (rst),
    .Go         (go),
    .SCL        (scl),
    .SDA        (sda),
    .Busy       (busy),
    .Done       (done),
    .AckError   (ack_err),
    .Temperature(temp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slot k counts SCL rising edges after START: 8 = address ACK, 9..16 MSB, 18..25 LSB.
  function automatic logic slave_low(input int k, input logic en, input logic [7:0] m,
                                     input logic [7:0] l);
    if (!en) return 1'b0;
    if (k == 8) return 1'b1;
    if (k >= 9 && k <= 16) return !m[3'(16 - k)];
    if (k >= 18 && k <= 25) return !l[3'(25 - k)];
    return 1'b0;
  endfunction

  function automatic logic [7:0] bus_byte(input logic [31:0] b, input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = b[5'(base + i)];
    return r;
  endfunction

  always @(negedge clk) begin
    scl_p <= scl;
    sda_p <= sda;
    if (mon_clr) begin
      start_cnt <= 0;
      stop_cnt  <= 0;
      done_cnt  <= 0;
      nrise     <= 0;
      bus_bits  <= 32'h0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (scl && scl_p && sda_p && !sda) begin
        start_cnt <= start_cnt + 1;
        nrise     <= 0;
      end else if (scl && scl_p && !sda_p && sda) begin
        stop_cnt <= stop_cnt + 1;
      end else if (scl && !scl_p) begin
        if (nrise < 32) bus_bits[nrise[4:0]] <= sda;
        nrise <= nrise + 1;
      end
    end
    if (rst) slv_drv <= 1'b0;
    else if (scl && scl_p && sda_p && !sda) slv_drv <= 1'b0;
    else if (!scl && scl_p) slv_drv <= slave_low(nrise, slave_en, slv_msb, slv_lsb);
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  // Pulses Go for one edge and returns how many edges (first = the accepting edge) until Done.
  task automatic run_read(input logic present, input logic [7:0] m, input logic [7:0] l,
                          output int lat, output logic busy1);
    slave_en = present;
    slv_msb  = m;
    slv_lsb  = l;
    clear_mon();
    go = 1'b1;
    @(posedge clk); #1;
    go    = 1'b0;
    lat   = 1;
    busy1 = busy;
    while (!done && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int   lat, gap, dones, cyc, last_done;
    logic busy1;
    rst = 1'b1; go = 1'b0; mon_clr = 1'b1;
    slave_en = 1'b0; slv_msb = 8'h00; slv_lsb = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_scl", 32'(scl), 32'd1);
    check_eq("rst_sda", 32'(sda), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_temp", 32'(temp), 32'h000);
    rst = 1'b0; mon_clr = 1'b0;
    @(posedge clk); #1;

    // Good read 0x19,0x40
    run_read(1'b1, 8'h19, 8'h40, lat, busy1);
    check_eq("good_latency", 32'(lat), 32'd465);
    check_eq("good_busy_after_go", 32'(busy1), 32'd1);
    check_eq("good_busy_at_done", 32'(busy), 32'd0);
    check_eq("good_temp", 32'(temp), 32'h000);
    check_eq("good_starts", 32'(start_cnt), 32'd1);
    check_eq("good_stops", 32'(stop_cnt), 32'd1);
    check_eq("good_addr_byte", 32'(bus_byte(bus_bits, 0)), 32'h91);
    check_eq("good_addr_ack", 32'(bus_bits[8]), 32'd0);
    check_eq("good_msb_on_bus", 32'(bus_byte(bus_bits, 9)), 32'h19);
    check_eq("good_master_ack", 32'(bus_bits[17]), 32'd0);
    check_eq("good_master_nack", 32'(bus_bits[26]), 32'd1);
    @(posedge clk); #1;
    check_eq("good_done_one_clk", 32'(done), 32'd0);
    check_eq("good_temp_loaded", 32'(temp), 32'h194);
    check_eq("good_ackerr", 32'(ack_err), 32'd0);

    // No slave: address NACK
    run_read(1'b0, 8'h00, 8'h00, lat, busy1);
    check_eq("nack_latency", 32'(lat), 32'd177);
    check_eq("nack_ackerr", 32'(ack_err), 32'd1);
    check_eq("nack_stops", 32'(stop_cnt), 32'd1);
    @(posedge clk); #1;
    check_eq("nack_temp_kept", 32'(temp), 32'h194);

    // Negative temperature; also clears the previous AckError
    run_read(1'b1, 8'hE7, 8'h00, lat, busy1);
    check_eq("neg_latency", 32'(lat), 32'd465);
    check_eq("neg_ackerr", 32'(ack_err), 32'd0);
    @(posedge clk); #1;
    check_eq("neg_temp", 32'(temp), 32'hE70);

    // Reset in the middle of the MSB byte
    slave_en = 1'b1; slv_msb = 8'h00; slv_lsb = 8'h00;
    clear_mon();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check_eq("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_scl", 32'(scl), 32'd1);
    check_eq("mid_rst_sda", 32'(sda), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_temp", 32'(temp), 32'h000);
    rst = 1'b0;
    @(posedge clk); #1;
    run_read(1'b1, 8'h7F, 8'hF0, lat, busy1);
    check_eq("post_rst_latency", 32'(lat), 32'd465);
    @(posedge clk); #1;
    check_eq("post_rst_temp", 32'(temp), 32'h7FF);

    // Go held high: two back-to-back transactions
    slave_en = 1'b1; slv_msb = 8'h19; slv_lsb = 8'h40;
    clear_mon();
    go = 1'b1;
    dones = 0; cyc = 0; last_done = 0; gap = 0;
    while (dones < 2 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        dones++;
        if (dones == 2) begin
          gap = cyc - last_done;
          go  = 1'b0;
        end
        last_done = cyc;
      end
    end
    check_eq("b2b_two_dones", 32'(dones), 32'd2);
    check_eq("b2b_gap", 32'(gap), 32'd466);
    repeat (600) @(posedge clk);
    #1;
    check_eq("b2b_done_count", 32'(done_cnt), 32'd2);
    check_eq("b2b_idle_after", 32'(busy), 32'd0);

    // Extra Go pulse while busy is ignored
    clear_mon();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    check_eq("busy_go_done_count", 32'(done_cnt), 32'd1);
    check_eq("busy_go_starts", 32'(start_cnt), 32'd1);
    check_eq("busy_go_temp", 32'(temp), 32'h194);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
